// File: rtl/ip_seq.sv
// Instruction pointer sequencer with a hardware return stack.
// Computes the next fetch address from skip/call/return/branch strobes,
// keeps a LIFO of return addresses and sticky over/underflow flags.
module ip_seq #(
    parameter int IADDR_WIDTH  = 10,
    parameter int RS_DEPTH     = 16,
    parameter int RESET_VECTOR = 0
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       stall,
    input  logic [IADDR_WIDTH-1:0]     TOS,
    input  logic                       TOS_is_zero,
    input  logic [IADDR_WIDTH-1:0]     ip_imm,
    input  logic                       ip_imm_sel,
    input  logic                       ip_call,
    input  logic                       ip_ret,
    input  logic                       ip_tos_sel,
    input  logic                       ip_skip,
    input  logic                       clr_err,
    output logic [IADDR_WIDTH-1:0]     IP,
    output logic [IADDR_WIDTH-1:0]     ip_next,
    output logic [IADDR_WIDTH-1:0]     ip_inc,
    output logic [IADDR_WIDTH-1:0]     rs_top,
    output logic [$clog2(RS_DEPTH):0]  rs_count,
    output logic                       rs_overflow,
    output logic                       rs_underflow
);

    localparam int PW = $clog2(RS_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0]          FULL = CW'(RS_DEPTH);
    localparam logic [IADDR_WIDTH-1:0] RV   = IADDR_WIDTH'(RESET_VECTOR);

    logic [IADDR_WIDTH-1:0] ip_q, ip_d;
    logic [IADDR_WIDTH-1:0] rs_top_q, rs_top_d;
    logic [CW-1:0]          rs_count_q, rs_count_d;
    logic                   ovf_q, ovf_d;
    logic                   unf_q, unf_d;
    logic [IADDR_WIDTH-1:0] mem_q [RS_DEPTH];

    logic          push_req, pop_req, unf_evt, ovf_evt, do_push;
    logic [PW-1:0] wr_idx, below_idx;

    assign ip_inc       = ip_q + IADDR_WIDTH'(1);
    assign IP           = ip_q;
    assign rs_top       = rs_top_q;
    assign rs_count     = rs_count_q;
    assign rs_overflow  = ovf_q;
    assign rs_underflow = unf_q;

    // Priority selection of the next IP and the requested stack operation
    always_comb begin
        ip_next  = ip_inc;
        push_req = 1'b0;
        pop_req  = 1'b0;
        unf_evt  = 1'b0;
        if (ip_skip && !TOS_is_zero) begin
            ip_next = ip_inc;
        end else if (ip_call) begin
            ip_next  = ip_tos_sel ? TOS : ip_imm;
            push_req = 1'b1;
        end else if (ip_ret) begin
            if (rs_count_q == '0) begin
                unf_evt = 1'b1;
            end else begin
                ip_next = ip_tos_sel ? TOS : rs_top_q;
                pop_req = 1'b1;
            end
        end else if (ip_imm_sel) begin
            ip_next = ip_tos_sel ? TOS : ip_imm;
        end
    end

    // Next-state for IP, stack pointer, cached top and sticky flags
    always_comb begin
        ovf_evt    = push_req && (rs_count_q == FULL);
        do_push    = push_req && !ovf_evt;
        wr_idx     = rs_count_q[PW-1:0];
        below_idx  = PW'(rs_count_q - CW'(2));
        ip_d       = ip_q;
        rs_count_d = rs_count_q;
        rs_top_d   = rs_top_q;
        ovf_d      = ovf_q & ~clr_err;
        unf_d      = unf_q & ~clr_err;
        if (!stall) begin
            ip_d = ip_next;
            if (do_push) begin
                rs_count_d = rs_count_q + CW'(1);
                rs_top_d   = ip_inc;
            end else if (pop_req) begin
                rs_count_d = rs_count_q - CW'(1);
                // the new top is the entry below the popped one, or 0 when emptied
                rs_top_d   = (rs_count_q > CW'(1)) ? mem_q[below_idx] : '0;
            end
            ovf_d = ovf_d | ovf_evt;
            unf_d = unf_d | unf_evt;
        end
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ip_q       <= RV;
            rs_top_q   <= '0;
            rs_count_q <= '0;
            ovf_q      <= 1'b0;
            unf_q      <= 1'b0;
        end else begin
            ip_q       <= ip_d;
            rs_top_q   <= rs_top_d;
            rs_count_q <= rs_count_d;
            ovf_q      <= ovf_d;
            unf_q      <= unf_d;
        end
    end

    // Return-stack storage; not cleared by reset
    always_ff @(posedge clk) begin
        if (rst_n && !stall && do_push) begin
            mem_q[wr_idx] <= ip_inc;
        end
    end

endmodule

// File: tb/tb_ip_seq.sv
// Self-checking bench for ip_seq: directed table, hand sequences and a
// randomized run, all checked against a queue-based reference model.
module tb_ip_seq;

    localparam int W     = 10;
    localparam int DEPTH = 16;
    localparam int MASK  = (1 << W) - 1;

    logic           clk = 1'b0;
    logic           rst_n, stall, TOS_is_zero, ip_imm_sel, ip_call, ip_ret;
    logic           ip_tos_sel, ip_skip, clr_err;
    logic [W-1:0]   TOS, ip_imm;
    logic [W-1:0]   IP, ip_next, ip_inc, rs_top;
    logic [4:0]     rs_count;
    logic           rs_overflow, rs_underflow;

    ip_seq #(.IADDR_WIDTH(W), .RS_DEPTH(DEPTH), .RESET_VECTOR(0)) dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .TOS(TOS),
        .TOS_is_zero(TOS_is_zero), .ip_imm(ip_imm), .ip_imm_sel(ip_imm_sel),
        .ip_call(ip_call), .ip_ret(ip_ret), .ip_tos_sel(ip_tos_sel),
        .ip_skip(ip_skip), .clr_err(clr_err), .IP(IP), .ip_next(ip_next),
        .ip_inc(ip_inc), .rs_top(rs_top), .rs_count(rs_count),
        .rs_overflow(rs_overflow), .rs_underflow(rs_underflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit rst_n, stall, skip, tz, imm_sel, call, ret, tos_sel, clr;
        int imm, tos;
    } in_t;

    typedef struct {
        in_t in;
        int  exp_ip;
        int  exp_cnt;
        bit  exp_unf;
    } vec_t;

    int n_checks = 0;
    int n_fail   = 0;

    // reference model state
    int m_ip;
    int m_rs[$];
    bit m_ovf, m_unf;
    bit m_valid = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic in_t idle();
        in_t x;
        x = '{rst_n: 1'b1, stall: 1'b0, skip: 1'b0, tz: 1'b0, imm_sel: 1'b0,
              call: 1'b0, ret: 1'b0, tos_sel: 1'b0, clr: 1'b0, imm: 0, tos: 0};
        return x;
    endfunction

    function automatic in_t jump(input int a);
        in_t x;
        x = idle();
        x.imm_sel = 1'b1;
        x.imm = a;
        return x;
    endfunction

    // One clock: drive, compare pre-edge outputs to the model, clock, advance model
    task automatic step(input in_t x);
        int inc, nxt, top;
        bit push, pop, ovfe, unfe;
        @(negedge clk);
        rst_n = x.rst_n; stall = x.stall; ip_skip = x.skip; TOS_is_zero = x.tz;
        ip_imm_sel = x.imm_sel; ip_call = x.call; ip_ret = x.ret;
        ip_tos_sel = x.tos_sel; clr_err = x.clr;
        ip_imm = W'(x.imm); TOS = W'(x.tos);
        #1;
        inc  = (m_ip + 1) & MASK;
        top  = (m_rs.size() > 0) ? m_rs[$] : 0;
        push = 0; pop = 0; ovfe = 0; unfe = 0;
        nxt  = inc;
        if (x.skip && !x.tz) nxt = inc;
        else if (x.call) begin nxt = x.tos_sel ? x.tos : x.imm; push = 1; end
        else if (x.ret) begin
            if (m_rs.size() == 0) unfe = 1;
            else begin nxt = x.tos_sel ? x.tos : top; pop = 1; end
        end
        else if (x.imm_sel) nxt = x.tos_sel ? x.tos : x.imm;
        if (m_valid) begin
            chk("IP", int'(IP), m_ip);
            chk("ip_inc", int'(ip_inc), inc);
            chk("ip_next", int'(ip_next), nxt);
            chk("rs_top", int'(rs_top), top);
            chk("rs_count", int'(rs_count), m_rs.size());
            chk("rs_overflow", int'(rs_overflow), int'(m_ovf));
            chk("rs_underflow", int'(rs_underflow), int'(m_unf));
        end
        @(posedge clk);
        if (!x.rst_n) begin
            m_ip = 0; m_rs.delete(); m_ovf = 0; m_unf = 0; m_valid = 1;
        end else if (x.stall) begin
            if (x.clr) begin m_ovf = 0; m_unf = 0; end
        end else begin
            m_ip = nxt;
            if (push) begin
                if (m_rs.size() == DEPTH) ovfe = 1;
                else m_rs.push_back(inc);
            end
            if (pop) void'(m_rs.pop_back());
            m_ovf = (m_ovf && !x.clr) || ovfe;
            m_unf = (m_unf && !x.clr) || unfe;
        end
        #1;
    endtask

    vec_t vecs[$];

    initial begin
        in_t x;
        vec_t v;

        // directed table: {inputs, IP after, rs_count after, rs_underflow after}
        x = idle(); x.rst_n = 0; v = '{x, 0, 0, 0}; vecs.push_back(v);
        x = idle();              v = '{x, 1, 0, 0}; vecs.push_back(v);
        v = '{x, 2, 0, 0}; vecs.push_back(v);
        v = '{x, 3, 0, 0}; vecs.push_back(v);
        v = '{jump(5), 5, 0, 0}; vecs.push_back(v);
        x = idle(); x.call = 1; x.imm = 'h100; v = '{x, 'h100, 1, 0}; vecs.push_back(v);
        x = idle(); x.ret = 1;  x.imm = 'h55;  v = '{x, 'h006, 0, 0}; vecs.push_back(v);
        v = '{jump('h20), 'h20, 0, 0}; vecs.push_back(v);
        x = idle(); x.ret = 1; x.tos_sel = 1; x.tos = 'h77; v = '{x, 'h21, 0, 1}; vecs.push_back(v);
        x = idle(); x.clr = 1;  v = '{x, 'h22, 0, 0}; vecs.push_back(v);
        v = '{jump(8), 8, 0, 0}; vecs.push_back(v);
        x = jump('h40); x.skip = 1; x.tz = 0; v = '{x, 9, 0, 0}; vecs.push_back(v);
        v = '{jump(8), 8, 0, 0}; vecs.push_back(v);
        x = jump('h40); x.skip = 1; x.tz = 1; x.stall = 1; v = '{x, 8, 0, 0}; vecs.push_back(v);
        x = jump('h40); x.skip = 1; x.tz = 1; v = '{x, 'h40, 0, 0}; vecs.push_back(v);
        v = '{jump('h3FF), 'h3FF, 0, 0}; vecs.push_back(v);
        v = '{idle(), 'h000, 0, 0}; vecs.push_back(v);

        foreach (vecs[i]) begin
            step(vecs[i].in);
            chk($sformatf("vec%0d IP", i), int'(IP), vecs[i].exp_ip);
            chk($sformatf("vec%0d rs_count", i), int'(rs_count), vecs[i].exp_cnt);
            chk($sformatf("vec%0d rs_underflow", i), int'(rs_underflow), int'(vecs[i].exp_unf));
        end
        chk("wrap ip_inc", int'(ip_inc), 'h001);

        // 17 calls into a 16-deep stack, then 16 returns in LIFO order
        step(jump('h10));
        for (int i = 0; i < 17; i++) begin
            x = idle(); x.call = 1; x.imm = 'h200 + i;
            step(x);
        end
        chk("ovf rs_count", int'(rs_count), 16);
        chk("ovf flag", int'(rs_overflow), 1);
        chk("ovf target", int'(IP), 'h210);
        for (int j = 0; j < 16; j++) begin
            x = idle(); x.ret = 1;
            step(x);
            chk($sformatf("lifo ret%0d", j), int'(IP), (j == 15) ? 'h11 : ('h200 + 15 - j));
        end
        chk("lifo empty top", int'(rs_top), 0);

        // overflow stays sticky; clr_err under stall clears it
        step(idle());
        chk("ovf sticky", int'(rs_overflow), 1);
        x = idle(); x.stall = 1; x.clr = 1; step(x);
        chk("clr under stall", int'(rs_overflow), 0);

        // new underflow coinciding with clr_err: set wins
        x = idle(); x.ret = 1; x.clr = 1; step(x);
        chk("set beats clr", int'(rs_underflow), 1);

        // call and ret together: call wins, no pop
        x = idle(); x.call = 1; x.ret = 1; x.tos_sel = 1; x.tos = 'h123; step(x);
        chk("call+ret IP", int'(IP), 'h123);
        chk("call+ret count", int'(rs_count), 1);

        // reset overrides an in-flight push
        x = idle(); x.rst_n = 0; x.call = 1; x.imm = 'h99; step(x);
        chk("rst over push IP", int'(IP), 0);
        chk("rst over push count", int'(rs_count), 0);
        chk("rst flags", int'(rs_underflow), 0);

        // randomized run: push-biased phase then pop-biased phase
        for (int c = 0; c < 3000; c++) begin
            int pc, pr;
            pc = (c < 1500) ? 40 : 15;
            pr = (c < 1500) ? 15 : 40;
            x.rst_n   = ($urandom_range(0, 199) != 0);
            x.stall   = ($urandom_range(0, 99) < 10);
            x.skip    = ($urandom_range(0, 99) < 10);
            x.tz      = $urandom_range(0, 1) != 0;
            x.imm_sel = ($urandom_range(0, 99) < 20);
            x.call    = ($urandom_range(0, 99) < pc);
            x.ret     = ($urandom_range(0, 99) < pr);
            x.tos_sel = ($urandom_range(0, 99) < 25);
            x.clr     = ($urandom_range(0, 99) < 5);
            x.imm     = int'($urandom & MASK);
            x.tos     = int'($urandom & MASK);
            step(x);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ip_seq.md
IP_SEQ -- requirements
Module: ip_seq

Interface
REQ-001 The block SHALL have parameter IADDR_WIDTH, default 10, the instruction address width.
REQ-002 The block SHALL have parameter RS_DEPTH, default 16 (power of two, >= 2), the return-stack entry count.
REQ-003 The block SHALL have parameter RESET_VECTOR, default 0, the IP value loaded at reset.
REQ-004 The block SHALL have port clk, input, 1, the single clock; all state changes occur on its rising edge.
REQ-005 The block SHALL have port rst_n, input, 1, the reset; it is synchronous and active-low.
REQ-006 The block SHALL have port stall, input, 1; when high, all state holds.
REQ-007 The block SHALL have port TOS, input, IADDR_WIDTH, the data-stack top used as an indirect target.
REQ-008 The block SHALL have port TOS_is_zero, input, 1, the condition for ip_skip.
REQ-009 The block SHALL have port ip_imm, input, IADDR_WIDTH, the immediate target.
REQ-010 The block SHALL have ports ip_imm_sel, ip_call, ip_ret, ip_tos_sel and ip_skip, inputs, 1 each, the control strobes.
REQ-011 The block SHALL have port clr_err, input, 1, which clears the sticky error flags.
REQ-012 The block SHALL have port IP, output, IADDR_WIDTH, the registered instruction pointer.
REQ-013 The block SHALL have port ip_next, output, IADDR_WIDTH, the combinational next IP for fetch look-ahead.
REQ-014 The block SHALL have port ip_inc, output, IADDR_WIDTH, equal to IP+1.
REQ-015 The block SHALL have port rs_top, output, IADDR_WIDTH, the return-stack top, or 0 when the stack is empty.
REQ-016 The block SHALL have port rs_count, output, clog2(RS_DEPTH)+1 bits, the number of occupied entries.
REQ-017 The block SHALL have ports rs_overflow and rs_underflow, outputs, 1 each, the sticky error flags.

Function
REQ-018 ip_inc SHALL equal IP+1 modulo 2^IADDR_WIDTH, so the all-ones IP wraps to 0.
REQ-019 ip_next SHALL be selected by first match in this order:
  - ip_skip && !TOS_is_zero -> ip_inc, no stack operation.
  - ip_call -> ip_tos_sel ? TOS : ip_imm, and push ip_inc.
  - ip_ret -> ip_tos_sel ? TOS : rs_top, and pop.
  - ip_imm_sel -> ip_tos_sel ? TOS : ip_imm.
  - otherwise -> ip_inc.
REQ-020 ip_skip with TOS_is_zero SHALL fall through to the remaining rules, so skip+imm_sel forms a branch-if-zero.
REQ-021 A push with rs_count < RS_DEPTH SHALL write ip_inc as the new top and increment rs_count, with 1-cycle latency.
REQ-022 A push with rs_count == RS_DEPTH SHALL leave the stack unchanged, set rs_overflow, and still take the branch target.
REQ-023 A pop with rs_count > 0 SHALL decrement rs_count; the popped value is the pre-edge rs_top.
REQ-024 A pop with rs_count == 0 SHALL make ip_next = ip_inc (ip_tos_sel ignored), leave the stack unchanged, and set rs_underflow.
REQ-025 When ip_call and ip_ret are both high, the call SHALL win and no pop SHALL occur.
REQ-026 Each clock edge with stall low SHALL load IP <= ip_next and apply the selected stack operation.
REQ-027 With stall high, IP, the stack, rs_count and the flags SHALL hold; ip_next SHALL still reflect the current inputs.
REQ-028 rs_overflow and rs_underflow SHALL stay set until clr_err or reset.
REQ-029 clr_err SHALL take effect even while stall is high.
REQ-030 If clr_err coincides with a new error, the flag SHALL be set (the set wins).
REQ-031 rs_top SHALL be a registered read and valid in the cycle after a push or pop.

Reset
REQ-032 While rst_n is low at a clock edge, the next state SHALL be: IP = RESET_VECTOR, rs_count = 0, rs_overflow = 0, rs_underflow = 0, rs_top = 0, regardless of stall or strobes.
REQ-033 Reset SHALL override any in-flight push or pop in that cycle.
REQ-034 Stack RAM contents need not be cleared by reset.

Verification
REQ-035 The bench SHALL cover this scenario: reset, then 3 idle cycles -> IP = 0,1,2,3 and rs_count = 0.
REQ-036 The bench SHALL cover this scenario: IP = 0x3FF, idle cycle (width 10) -> IP = 0x000, ip_inc = 0x001.
REQ-037 The bench SHALL cover this scenario: at IP = 5, ip_call with ip_imm = 0x100, then ip_ret at 0x100 -> IP = 0x100 then 0x006; rs_count 1 then 0.
REQ-038 The bench SHALL cover this scenario: 17 calls with RS_DEPTH = 16 -> rs_count = 16, rs_overflow = 1 after the 17th; 16 rets return in LIFO order.
REQ-039 The bench SHALL cover this scenario: ip_ret on an empty stack at IP = 0x20 -> IP = 0x21, rs_underflow = 1; clr_err -> 0.
REQ-040 The bench SHALL cover this scenario: ip_skip + ip_imm_sel, ip_imm = 0x40, at IP = 8 -> with TOS_is_zero = 0, IP = 9; with TOS_is_zero = 1, IP = 0x40; with stall high, IP holds at 8.
